// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_pkg
//  Purpose  : Shared types and constants for the parametrised memory-bus
//             router: the FSM state encoding, the error cause codes and the
//             default read data returned on an error.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    // Router transaction states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Sticky error-log cause codes
    typedef enum logic [1:0] {
        NONE     = 2'd0,
        UNMAPPED = 2'd1,
        TIMEOUT  = 2'd2
    } err_cause_t;

    // Read data handed back to the core when an access fails
    localparam logic [31:0] c_ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/mem_bus_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_addr_decode
//  Purpose  : Purely combinational base/mask address decoder. Target i
//             matches when (i_addr & mask_i) == base_i; when several targets
//             match, the lowest index wins.
//  Ports    : i_addr [31:0]      request address
//             o_hit              at least one target matches
//             o_idx [IDX_W-1:0]  index of the winning target (0 on miss)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_addr_decode
    import mem_bus_pkg::*;
#(
    parameter int                  N_TGT    = 3,
    parameter int                  IDX_W    = (N_TGT > 1) ? $clog2(N_TGT) : 1,
    parameter logic [N_TGT*32-1:0] TGT_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [N_TGT*32-1:0] TGT_MASK = {32'hFFFF_F000, 32'hF000_0000, 32'hFFFF_0000}
) (
    input  logic [31:0]      i_addr,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_idx
);

    logic [N_TGT-1:0] w_match;

    generate
        for (genvar g = 0; g < N_TGT; g++) begin : g_match
            assign w_match[g] = ((i_addr & TGT_MASK[g*32 +: 32]) == TGT_BASE[g*32 +: 32]);
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the last write.
    always_comb begin
        o_hit = |w_match;
        o_idx = '0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_router.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_router
//  Purpose  : Routes one picorv32-native request stream to N_TGT native-bus
//             targets by base/mask decode. The request is registered onto a
//             shared target bus; a per-transaction timer aborts hung
//             targets, and unmapped or aborted accesses complete with an
//             error response while being recorded in a sticky error log.
//  Ports    : clk, reset                  clock, async active-high reset
//             mem_valid/instr/addr/wdata/wstrb  core request
//             mem_ready, mem_rdata        core completion pulse and data
//             tgt_valid[N_TGT]            one-hot per-target request
//             tgt_instr/addr/wdata/wstrb  registered shared target bus
//             tgt_ready[N_TGT], tgt_rdata per-target completion and data
//             err_clear                   clears the error log
//             err_valid/cause/addr/count  sticky error log
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_router
    import mem_bus_pkg::*;
#(
    parameter int                  N_TGT     = 3,
    parameter logic [N_TGT*32-1:0] TGT_BASE  = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [N_TGT*32-1:0] TGT_MASK  = {32'hFFFF_F000, 32'hF000_0000, 32'hFFFF_0000},
    parameter int                  TIMEOUT   = 256,
    parameter logic [31:0]         ERR_RDATA = c_ERR_RDATA_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_valid,
    input  logic                mem_instr,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wstrb,
    output logic                mem_ready,
    output logic [31:0]         mem_rdata,
    output logic [N_TGT-1:0]    tgt_valid,
    output logic                tgt_instr,
    output logic [31:0]         tgt_addr,
    output logic [31:0]         tgt_wdata,
    output logic [3:0]          tgt_wstrb,
    input  logic [N_TGT-1:0]    tgt_ready,
    input  logic [N_TGT*32-1:0] tgt_rdata,
    input  logic                err_clear,
    output logic                err_valid,
    output logic [1:0]          err_cause,
    output logic [31:0]         err_addr,
    output logic [7:0]          err_count
);

    localparam int                  c_IDX_W     = (N_TGT > 1) ? $clog2(N_TGT) : 1;
    localparam int                  c_TMR_W     = $clog2(TIMEOUT);
    localparam logic [c_TMR_W-1:0]  c_TMR_LIMIT = c_TMR_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_TMR_W-1:0]   r_timer;
    logic [N_TGT-1:0]     r_tgt_valid;
    logic                 r_tgt_instr;
    logic [31:0]          r_tgt_addr;
    logic [31:0]          r_tgt_wdata;
    logic [3:0]           r_tgt_wstrb;
    logic [31:0]          r_rdata;

    logic                 r_err_valid;
    err_cause_t           r_err_cause;
    logic [31:0]          r_err_addr;
    logic [7:0]           r_err_count;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                 w_hit;
    logic [c_IDX_W-1:0]   w_idx;
    logic [31:0]          w_rdata_arr [N_TGT];
    logic                 w_sel_ready;
    logic [31:0]          w_sel_rdata;
    logic                 w_is_read;
    logic                 w_err_unmapped;
    logic                 w_err_timeout;
    logic                 w_err_event;
    err_cause_t           w_err_cause_new;
    logic [31:0]          w_err_addr_new;
    logic [31:0]          w_mem_rdata;

    mem_bus_addr_decode #(
        .N_TGT    (N_TGT),
        .IDX_W    (c_IDX_W),
        .TGT_BASE (TGT_BASE),
        .TGT_MASK (TGT_MASK)
    ) u_decode (
        .i_addr (mem_addr),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    generate
        for (genvar g = 0; g < N_TGT; g++) begin : g_rdata
            assign w_rdata_arr[g] = tgt_rdata[g*32 +: 32];
        end
    endgenerate

    // Only the selected target's handshake is observed; others are ignored.
    assign w_sel_ready = tgt_ready[r_idx];
    assign w_sel_rdata = w_rdata_arr[r_idx];
    assign w_is_read   = (r_tgt_wstrb == 4'h0);

    // Ready in the final timer cycle still completes normally.
    assign w_err_unmapped  = (r_state == IDLE) && mem_valid && !w_hit;
    assign w_err_timeout   = (r_state == REQ) && !w_sel_ready && (r_timer == c_TMR_LIMIT);
    assign w_err_event     = w_err_unmapped || w_err_timeout;
    assign w_err_cause_new = w_err_unmapped ? UNMAPPED : mem_bus_pkg::TIMEOUT;
    assign w_err_addr_new  = w_err_unmapped ? mem_addr : r_tgt_addr;

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_timer     <= '0;
            r_tgt_valid <= '0;
            r_tgt_instr <= 1'b0;
            r_tgt_addr  <= '0;
            r_tgt_wdata <= '0;
            r_tgt_wstrb <= '0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mem_valid) begin
                        r_tgt_instr <= mem_instr;
                        r_tgt_addr  <= mem_addr;
                        r_tgt_wdata <= mem_wdata;
                        r_tgt_wstrb <= mem_wstrb;
                        r_timer     <= '0;
                        if (w_hit) begin
                            r_idx <= w_idx;
                            for (int i = 0; i < N_TGT; i++) begin
                                r_tgt_valid[i] <= (w_idx == c_IDX_W'(i));
                            end
                            r_state <= REQ;
                        end else begin
                            r_state <= ERR;
                        end
                    end
                end
                REQ: begin
                    if (w_sel_ready) begin
                        r_rdata     <= w_sel_rdata;
                        r_tgt_valid <= '0;
                        r_state     <= RESP;
                    end else if (r_timer == c_TMR_LIMIT) begin
                        r_tgt_valid <= '0;
                        r_state     <= ERR;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RESP:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error log: first cause/address kept, count saturates.
    // A clear in the same cycle as a new error yields a log holding
    // just that new error.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_valid <= 1'b0;
            r_err_cause <= NONE;
            r_err_addr  <= '0;
            r_err_count <= '0;
        end else if (w_err_event) begin
            r_err_valid <= 1'b1;
            if (!r_err_valid || err_clear) begin
                r_err_cause <= w_err_cause_new;
                r_err_addr  <= w_err_addr_new;
            end
            if (err_clear) begin
                r_err_count <= 8'd1;
            end else if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end else if (err_clear) begin
            r_err_valid <= 1'b0;
            r_err_cause <= NONE;
            r_err_addr  <= '0;
            r_err_count <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Core response: data only for reads, zero for writes
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_rdata = '0;
        if (w_is_read) begin
            if (r_state == RESP) begin
                w_mem_rdata = r_rdata;
            end else if (r_state == ERR) begin
                w_mem_rdata = ERR_RDATA;
            end
        end
    end

    assign mem_ready = (r_state == RESP) || (r_state == ERR);
    assign mem_rdata = w_mem_rdata;
    assign tgt_valid = r_tgt_valid;
    assign tgt_instr = r_tgt_instr;
    assign tgt_addr  = r_tgt_addr;
    assign tgt_wdata = r_tgt_wdata;
    assign tgt_wstrb = r_tgt_wstrb;
    assign err_valid = r_err_valid;
    assign err_cause = r_err_cause;
    assign err_addr  = r_err_addr;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_router
//  Purpose  : Directed self-checking bench for mem_bus_router with the
//             default three-target map (tgt0 0x0000_xxxx, tgt1 0x1xxx_xxxx,
//             tgt2 0x2000_0xxx) and TIMEOUT = 256.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_router;

    localparam int N_TGT = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               mem_valid;
    logic               mem_instr;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [3:0]         mem_wstrb;
    logic               mem_ready;
    logic [31:0]        mem_rdata;
    logic [N_TGT-1:0]   tgt_valid;
    logic               tgt_instr;
    logic [31:0]        tgt_addr;
    logic [31:0]        tgt_wdata;
    logic [3:0]         tgt_wstrb;
    logic [N_TGT-1:0]   tgt_ready;
    logic [N_TGT*32-1:0] tgt_rdata;
    logic               err_clear;
    logic               err_valid;
    logic [1:0]         err_cause;
    logic [31:0]        err_addr;
    logic [7:0]         err_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_bus_router #(
        .N_TGT   (N_TGT),
        .TIMEOUT (256)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .tgt_valid (tgt_valid),
        .tgt_instr (tgt_instr),
        .tgt_addr  (tgt_addr),
        .tgt_wdata (tgt_wdata),
        .tgt_wstrb (tgt_wstrb),
        .tgt_ready (tgt_ready),
        .tgt_rdata (tgt_rdata),
        .err_clear (err_clear),
        .err_valid (err_valid),
        .err_cause (err_cause),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0;
        mem_wstrb = '0; tgt_ready = '0; tgt_rdata = '0; err_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step(); step();
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ready: got %b want 0", mem_ready); end
        n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_rdata: got %h want 0", mem_rdata); end
        n_checks++; if (tgt_valid !== 3'b000) begin n_fail++; $display("FAIL rst_tgt_valid: got %b want 000", tgt_valid); end
        n_checks++; if (tgt_addr !== 32'h0) begin n_fail++; $display("FAIL rst_tgt_addr: got %h want 0", tgt_addr); end
        n_checks++; if ({err_valid, err_cause, err_count} !== 11'h0) begin n_fail++; $display("FAIL rst_err_log: got v=%b c=%0d n=%0d want 0", err_valid, err_cause, err_count); end
        reset = 1'b0;
        step();
    endtask

    // Read from tgt0; ready three cycles after tgt_valid, with a stray ready
    // on tgt1 that must be ignored.
    task automatic test_read();
        mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h0000_0100; mem_wstrb = 4'h0;
        step(); // cycle 1
        n_checks++; if (tgt_valid !== 3'b001) begin n_fail++; $display("FAIL rd_tgt_valid: got %b want 001", tgt_valid); end
        n_checks++; if (tgt_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL rd_tgt_addr: got %h want 00000100", tgt_addr); end
        n_checks++; if (tgt_instr !== 1'b1) begin n_fail++; $display("FAIL rd_tgt_instr: got %b want 1", tgt_instr); end
        tgt_ready = 3'b010; tgt_rdata = {32'h0, 32'h1111_1111, 32'h0};
        step(); // cycle 2
        tgt_ready = '0; tgt_rdata = '0;
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL rd_foreign_ready: got mem_ready %b want 0", mem_ready); end
        step(); // cycle 3
        step(); // cycle 4
        n_checks++; if (tgt_valid !== 3'b001) begin n_fail++; $display("FAIL rd_hold_valid: got %b want 001", tgt_valid); end
        tgt_ready = 3'b001; tgt_rdata = {32'h0, 32'h0, 32'h1234_5678};
        step(); // cycle 5
        tgt_ready = '0; tgt_rdata = '0;
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL rd_mem_ready: got %b want 1", mem_ready); end
        n_checks++; if (mem_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_mem_rdata: got %h want 12345678", mem_rdata); end
        n_checks++; if (tgt_valid !== 3'b000) begin n_fail++; $display("FAIL rd_valid_drop: got %b want 000", tgt_valid); end
        n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL rd_err_valid: got %b want 0", err_valid); end
        mem_valid = 1'b0; mem_instr = 1'b0;
        step(); // cycle 6
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_pulse: got %b want 0", mem_ready); end
    endtask

    task automatic test_write();
        mem_valid = 1'b1; mem_addr = 32'h1000_0040; mem_wdata = 32'hCAFE_F00D; mem_wstrb = 4'hF;
        step(); // cycle 1
        n_checks++; if (tgt_valid !== 3'b010) begin n_fail++; $display("FAIL wr_tgt_valid: got %b want 010", tgt_valid); end
        n_checks++; if (tgt_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wr_tgt_wdata: got %h want cafef00d", tgt_wdata); end
        n_checks++; if (tgt_wstrb !== 4'hF) begin n_fail++; $display("FAIL wr_tgt_wstrb: got %h want f", tgt_wstrb); end
        tgt_ready = 3'b010; tgt_rdata = {32'h0, 32'h5555_5555, 32'h0};
        step(); // cycle 2
        tgt_ready = '0; tgt_rdata = '0;
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL wr_mem_ready: got %b want 1", mem_ready); end
        n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_mem_rdata: got %h want 0", mem_rdata); end
        mem_valid = 1'b0; mem_wdata = '0; mem_wstrb = '0;
        step();
    endtask

    task automatic test_unmapped();
        mem_valid = 1'b1; mem_addr = 32'h3000_0000; mem_wstrb = 4'h0;
        step(); // cycle 1
        n_checks++; if (tgt_valid !== 3'b000) begin n_fail++; $display("FAIL um_tgt_valid: got %b want 000", tgt_valid); end
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL um_mem_ready: got %b want 1", mem_ready); end
        n_checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL um_mem_rdata: got %h want deadbeef", mem_rdata); end
        mem_valid = 1'b0;
        step();
        n_checks++; if (err_valid !== 1'b1) begin n_fail++; $display("FAIL um_err_valid: got %b want 1", err_valid); end
        n_checks++; if (err_cause !== 2'd1) begin n_fail++; $display("FAIL um_err_cause: got %0d want 1", err_cause); end
        n_checks++; if (err_addr !== 32'h3000_0000) begin n_fail++; $display("FAIL um_err_addr: got %h want 30000000", err_addr); end
        n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL um_err_count: got %0d want 1", err_count); end
    endtask

    task automatic test_timeout();
        int cnt;
        logic early_ready;
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        n_checks++; if ({err_valid, err_cause, err_addr, err_count} !== 43'h0) begin n_fail++; $display("FAIL to_pre_clear: got v=%b c=%0d a=%h n=%0d want 0", err_valid, err_cause, err_addr, err_count); end

        mem_valid = 1'b1; mem_addr = 32'h2000_0010; mem_wstrb = 4'h0;
        step(); // cycle 1
        cnt = 0; early_ready = 1'b0;
        while (tgt_valid === 3'b100 && cnt < 400) begin
            if (mem_ready !== 1'b0) early_ready = 1'b1;
            cnt++;
            step();
        end
        n_checks++; if (cnt != 256) begin n_fail++; $display("FAIL to_valid_cycles: got %0d want 256", cnt); end
        n_checks++; if (early_ready !== 1'b0) begin n_fail++; $display("FAIL to_early_ready: got %b want 0", early_ready); end
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL to_mem_ready: got %b want 1", mem_ready); end
        n_checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_mem_rdata: got %h want deadbeef", mem_rdata); end
        mem_valid = 1'b0;
        step();
        n_checks++; if (err_cause !== 2'd2) begin n_fail++; $display("FAIL to_err_cause: got %0d want 2", err_cause); end
        n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL to_err_count: got %0d want 1", err_count); end

        // Second error must not overwrite the first cause/address.
        mem_valid = 1'b1; mem_addr = 32'h3000_0004;
        step();
        mem_valid = 1'b0;
        step();
        n_checks++; if (err_addr !== 32'h2000_0010) begin n_fail++; $display("FAIL to_err_addr_kept: got %h want 20000010", err_addr); end
        n_checks++; if (err_cause !== 2'd2) begin n_fail++; $display("FAIL to_err_cause_kept: got %0d want 2", err_cause); end
        n_checks++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL to_err_count2: got %0d want 2", err_count); end

        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        n_checks++; if ({err_valid, err_cause, err_addr, err_count} !== 43'h0) begin n_fail++; $display("FAIL to_clear: got v=%b c=%0d a=%h n=%0d want 0", err_valid, err_cause, err_addr, err_count); end

        // Clear coinciding with a fresh error: the new error is logged.
        step();
        mem_valid = 1'b1; mem_addr = 32'h3000_0008; err_clear = 1'b0;
        step(); // router now in ERR, the error was logged at this edge with no clear
        mem_valid = 1'b0;
        step();
        err_clear = 1'b1; mem_valid = 1'b1; mem_addr = 32'h3000_000C;
        step();
        err_clear = 1'b0; mem_valid = 1'b0;
        n_checks++; if (err_valid !== 1'b1) begin n_fail++; $display("FAIL sw_err_valid: got %b want 1", err_valid); end
        n_checks++; if (err_addr !== 32'h3000_000C) begin n_fail++; $display("FAIL sw_err_addr: got %h want 3000000c", err_addr); end
        n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL sw_err_count: got %0d want 1", err_count); end
        step();
    endtask

    // Ready in the very last allowed cycle must beat the timeout.
    task automatic test_timeout_boundary();
        logic [7:0] cnt_before;
        cnt_before = err_count;
        mem_valid = 1'b1; mem_addr = 32'h2000_0020; mem_wstrb = 4'h0;
        step(); // cycle 1, timer 0
        repeat (255) step(); // cycle 256, timer 255
        n_checks++; if (tgt_valid !== 3'b100) begin n_fail++; $display("FAIL tb_last_valid: got %b want 100", tgt_valid); end
        tgt_ready = 3'b100; tgt_rdata = {32'h0BEE_F00D, 64'h0};
        step();
        tgt_ready = '0; tgt_rdata = '0;
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL tb_mem_ready: got %b want 1", mem_ready); end
        n_checks++; if (mem_rdata !== 32'h0BEE_F00D) begin n_fail++; $display("FAIL tb_mem_rdata: got %h want 0beef00d", mem_rdata); end
        mem_valid = 1'b0;
        step();
        n_checks++; if (err_count !== cnt_before) begin n_fail++; $display("FAIL tb_err_count: got %0d want %0d", err_count, cnt_before); end
    endtask

    task automatic test_err_saturate();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        for (int i = 0; i < 260; i++) begin
            mem_valid = 1'b1; mem_addr = 32'h4000_0000 + 32'(i);
            step();
            mem_valid = 1'b0;
            step();
        end
        n_checks++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL sat_err_count: got %h want ff", err_count); end
        n_checks++; if (err_addr !== 32'h4000_0000) begin n_fail++; $display("FAIL sat_err_addr: got %h want 40000000", err_addr); end
    endtask

    task automatic test_reset_mid();
        logic bad;
        mem_valid = 1'b1; mem_addr = 32'h0000_0200; mem_wstrb = 4'h0;
        step(); // cycle 1, REQ
        n_checks++; if (tgt_valid !== 3'b001) begin n_fail++; $display("FAIL rm_pre_valid: got %b want 001", tgt_valid); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (tgt_valid !== 3'b000) begin n_fail++; $display("FAIL rm_async_valid: got %b want 000", tgt_valid); end
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL rm_async_ready: got %b want 0", mem_ready); end
        mem_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            step();
            if (mem_ready !== 1'b0 || tgt_valid !== 3'b000) bad = 1'b1;
        end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rm_no_ready: got stray activity %b want 0", bad); end
        n_checks++; if ({err_valid, err_count} !== 9'h0) begin n_fail++; $display("FAIL rm_err_log: got v=%b n=%0d want 0", err_valid, err_count); end

        mem_valid = 1'b1; mem_addr = 32'h0000_0000;
        step(); // cycle 1
        n_checks++; if (tgt_valid !== 3'b001) begin n_fail++; $display("FAIL rm_new_valid: got %b want 001", tgt_valid); end
        tgt_ready = 3'b001; tgt_rdata = {64'h0, 32'h5A5A_0001};
        step(); // cycle 2
        tgt_ready = '0; tgt_rdata = '0;
        n_checks++; if (mem_ready !== 1'b1 || mem_rdata !== 32'h5A5A_0001) begin n_fail++; $display("FAIL rm_new_read: got ready %b data %h want 1 5a5a0001", mem_ready, mem_rdata); end
        mem_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int          sel;
        logic [31:0] data;
        for (int i = 0; i < 300; i++) begin
            sel  = i % 2;
            data = 32'hA000_0000 + 32'(i);
            mem_valid = 1'b1; mem_wstrb = 4'h0;
            mem_addr  = (sel == 0) ? (32'h0000_0000 + 32'(i*4)) : (32'h1000_0000 + 32'(i*4));
            step(); // cycle 1
            n_checks++; if (tgt_valid !== 3'(1 << sel) || mem_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_req[%0d]: got valid %b ready %b want %b 0", i, tgt_valid, mem_ready, 3'(1 << sel)); end
            step(); // cycle 2
            tgt_ready = 3'(1 << sel);
            tgt_rdata = {3{32'h0BAD_0BAD}};
            tgt_rdata[sel*32 +: 32] = data;
            step(); // cycle 3
            tgt_ready = '0; tgt_rdata = '0;
            n_checks++; if (mem_ready !== 1'b1 || mem_rdata !== data) begin n_fail++; $display("FAIL b2b_resp[%0d]: got ready %b data %h want 1 %h", i, mem_ready, mem_rdata, data); end
            mem_valid = 1'b0;
            step(); // cycle 4, back in IDLE
            n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse[%0d]: got ready %b want 0", i, mem_ready); end
        end
        n_checks++; if (err_count !== 8'd0 || err_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got v=%b n=%0d want 0 0", err_valid, err_count); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_timeout_boundary();
        test_err_saturate();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
